// File: rtl/bfly_ctrl_pkg.sv
// Shared types and helpers for the butterfly transpose sequencing controller.
//   state_t  : frame FSM states (IDLE, STREAM, FLUSH)
//   tag_t    : per-row tag carried alongside the row through the stages
//   stage_bit: the switch setting a given stage applies for a tagged row
package bfly_ctrl_pkg;

  // Row index field is sized for networks up to 256 inputs; narrower
  // row counters are zero-extended into it.
  localparam int TAG_ROW_W = 8;
  localparam int SEL_W     = $clog2(TAG_ROW_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  typedef struct packed {
    logic [TAG_ROW_W-1:0] row_idx;
    logic                 mode;   // 0 = transpose, 1 = pass-through
    logic                 last;   // final row of the frame
  } tag_t;

  // Transpose: stage s swaps according to bit s of the row index.
  // Pass-through: every switch stays straight.
  function automatic logic stage_bit(input tag_t t, input logic [SEL_W-1:0] stage);
    return t.mode ? 1'b0 : t.row_idx[stage];
  endfunction

endpackage

// File: rtl/bfly_ctrl_skew.sv
// Tag skew pipeline: one tag slot per butterfly stage so each stage sees the
// control belonging to the row currently inside it.
//   clk, rst        : clock, synchronous active-low reset
//   i_valid, i_tag  : tag entering with the row being accepted this cycle
//   o_stage_ctrls   : per-stage switch controls, index 0 = first stage
//   o_out_valid     : a tag sits at the network output position
//   o_out_last      : that tag marks the final row of a frame
//   o_any_valid     : any tag still in flight
module bfly_ctrl_skew
  import bfly_ctrl_pkg::*;
#(
  parameter int NUM_STAGES   = 4,
  parameter int NUM_SWITCHES = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_valid,
  input  tag_t                                  i_tag,
  output logic [NUM_STAGES-1:0][NUM_SWITCHES-1:0] o_stage_ctrls,
  output logic                                  o_out_valid,
  output logic                                  o_out_last,
  output logic                                  o_any_valid
);

  // Slot s holds the tag of the row accepted s cycles ago; slot NUM_STAGES
  // lines up with the last stage's out_val.
  logic [NUM_STAGES:1] r_valid;
  tag_t [NUM_STAGES:1] r_tag;
  logic                w_unused_tag;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= '0;
      r_tag   <= '0;
    end else begin
      r_valid <= {r_valid[NUM_STAGES-1:1], i_valid};
      r_tag   <= {r_tag[NUM_STAGES-1:1], i_tag};
    end
  end

  // Stage 0 samples upstream data at the end of the accept cycle, so its
  // control comes straight from the incoming tag.
  assign o_stage_ctrls[0] = i_valid ? {NUM_SWITCHES{stage_bit(i_tag, SEL_W'(0))}} : '0;

  for (genvar s = 1; s < NUM_STAGES; s++) begin : g_stage
    assign o_stage_ctrls[s] =
      r_valid[s] ? {NUM_SWITCHES{stage_bit(r_tag[s], SEL_W'(s))}} : '0;
  end

  assign o_out_valid  = r_valid[NUM_STAGES];
  assign o_out_last   = r_tag[NUM_STAGES].last;
  assign o_any_valid  = |r_valid;
  // Only some tag fields are consumed at each slot.
  assign w_unused_tag = ^r_tag;

endmodule

// File: rtl/butterfly_transpose_ctrl.sv
// Sequencing controller for a registered multi-stage butterfly network.
// Accepts rows from upstream, drives stage 0's in_val, generates skewed
// per-stage switch controls, tracks frames of NUM_INPUTS rows and gates
// acceptance on downstream credits (the stages cannot stall).
//
// Handshake: a row transfers in every cycle where s_valid && s_ready.
// s_ready never depends on s_valid; s_valid must hold its row until taken.
//
// Ports:
//   clk, rst       : clock, synchronous active-low reset
//   s_valid/s_ready: upstream row handshake
//   cfg_mode       : 0 = transpose, 1 = pass-through, sampled on first row
//   net_in_val     : stage 0 in_val (the accept strobe)
//   stage_ctrls    : per-stage switch controls, index 0 = first stage
//   net_out_val    : out_val of the last stage
//   credit_return  : downstream freed one buffer slot
//   frame_done     : pulse as the frame's last row leaves the network
//   busy           : FSM not idle or rows in flight
//   credit_err     : sticky, credit returned while counter full
//   dbg_state      : current FSM state
//   dbg_credits    : current credit count
module butterfly_transpose_ctrl
  import bfly_ctrl_pkg::*;
#(
  parameter  int NUM_INPUTS   = 16,
  parameter  int NUM_STAGES   = $clog2(NUM_INPUTS),
  parameter  int CREDITS      = 4,
  localparam int NUM_SWITCHES = NUM_INPUTS / 2,
  localparam int CW           = $clog2(CREDITS + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic                                  cfg_mode,
  output logic                                  net_in_val,
  output logic [NUM_STAGES-1:0][NUM_SWITCHES-1:0] stage_ctrls,
  input  logic                                  net_out_val,
  input  logic                                  credit_return,
  output logic                                  frame_done,
  output logic                                  busy,
  output logic                                  credit_err,
  output state_t                                dbg_state,
  output logic [CW-1:0]                         dbg_credits
);

  localparam int             ROW_W     = $clog2(NUM_INPUTS);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(NUM_INPUTS - 1);
  localparam logic [CW-1:0]    CRED_FULL = CW'(CREDITS);

  state_t           r_state;
  logic [ROW_W-1:0] r_row_idx;
  logic             r_mode;
  logic [CW-1:0]    r_credits;
  logic             r_credit_err;

  logic w_accept;
  tag_t w_tag;
  logic w_out_valid;
  logic w_out_last;
  logic w_any_valid;

  assign s_ready    = rst && (r_state != FLUSH) && (r_credits != '0);
  assign w_accept   = s_valid && s_ready;
  assign net_in_val = w_accept;

  // In IDLE the row being accepted is row 0 and takes the live mode.
  always_comb begin
    w_tag         = '0;
    w_tag.row_idx = TAG_ROW_W'(r_row_idx);
    w_tag.mode    = r_mode;
    w_tag.last    = (r_state == STREAM) && (r_row_idx == LAST_ROW);
    if (r_state == IDLE) begin
      w_tag.row_idx = '0;
      w_tag.mode    = cfg_mode;
    end
  end

  bfly_ctrl_skew #(
    .NUM_STAGES  (NUM_STAGES),
    .NUM_SWITCHES(NUM_SWITCHES)
  ) u_skew (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (w_accept),
    .i_tag        (w_tag),
    .o_stage_ctrls(stage_ctrls),
    .o_out_valid  (w_out_valid),
    .o_out_last   (w_out_last),
    .o_any_valid  (w_any_valid)
  );

  assign frame_done = net_out_val && w_out_valid && w_out_last;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_row_idx <= '0;
      r_mode    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_row_idx <= ROW_W'(1);
          r_mode    <= cfg_mode;
          r_state   <= STREAM;
        end
        STREAM: if (w_accept) begin
          r_row_idx <= r_row_idx + ROW_W'(1);
          if (r_row_idx == LAST_ROW) r_state <= FLUSH;
        end
        FLUSH: if (frame_done) begin
          r_row_idx <= '0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Simultaneous accept and return cancel out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_credits    <= CRED_FULL;
      r_credit_err <= 1'b0;
    end else begin
      case ({w_accept, credit_return})
        2'b10: r_credits <= r_credits - CW'(1);
        2'b01: begin
          if (r_credits == CRED_FULL) r_credit_err <= 1'b1;
          else                        r_credits    <= r_credits + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != IDLE) || w_any_valid;
  assign credit_err  = r_credit_err;
  assign dbg_state   = r_state;
  assign dbg_credits = r_credits;

endmodule

// File: tb/tb_butterfly_transpose_ctrl.sv
module tb_butterfly_transpose_ctrl;
  import bfly_ctrl_pkg::*;

  localparam int NI  = 16;
  localparam int NS  = 4;
  localparam int NSW = 8;
  localparam int C   = 4;
  localparam int CW  = 3;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;
  logic s_valid = 1'b0;
  logic cfg_mode = 1'b0;
  logic credit_return = 1'b0;
  logic s_ready, net_in_val, frame_done, busy, credit_err;
  logic net_out_val;
  logic [NS-1:0][NSW-1:0] stage_ctrls;
  state_t dbg_state;
  logic [CW-1:0] dbg_credits;

  butterfly_transpose_ctrl #(.NUM_INPUTS(NI), .NUM_STAGES(NS), .CREDITS(C)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .cfg_mode(cfg_mode), .net_in_val(net_in_val), .stage_ctrls(stage_ctrls),
    .net_out_val(net_out_val), .credit_return(credit_return),
    .frame_done(frame_done), .busy(busy), .credit_err(credit_err),
    .dbg_state(dbg_state), .dbg_credits(dbg_credits)
  );

  // Stand-in for the network: out_val is in_val delayed by NS registers.
  logic [NS-1:0] nv_sr = '0;
  always @(posedge clk) begin
    if (!rst) nv_sr <= '0;
    else      nv_sr <= {nv_sr[NS-2:0], net_in_val};
  end
  assign net_out_val = nv_sr[NS-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Behavioural model: history of accepted rows indexed by cycle number.
  logic h_v[64];
  logic h_m[64];
  logic h_l[64];
  int   h_r[64];
  int   m_rows = 0;
  logic m_wait = 1'b0;
  logic m_mode = 1'b0;
  int   m_credits = C;
  logic m_err = 1'b0;

  logic [NS-1:0][NSW-1:0] snap_ctrl[64];
  logic snap_done[64];
  logic snap_ready[64];

  initial for (int i = 0; i < 64; i++) begin
    h_v[i] = 1'b0; h_m[i] = 1'b0; h_l[i] = 1'b0; h_r[i] = 0;
  end

  always @(negedge clk) begin : compare
    logic exp_ready, exp_acc, exp_done, exp_busy, cur_mode;
    logic [NS-1:0][NSW-1:0] exp_ctrl;
    logic [1:0] exp_state;
    int cur_row, idx;

    exp_ready = rst && !m_wait && (m_credits != 0);
    exp_acc   = s_valid && exp_ready;
    cur_row   = m_rows;
    cur_mode  = (m_rows == 0) ? cfg_mode : m_mode;

    exp_ctrl = '0;
    if (exp_acc && !cur_mode && (cur_row % 2 == 1)) exp_ctrl[0] = '1;
    for (int s = 1; s < NS; s++) begin
      idx = (cyc - s) & 63;
      if (h_v[idx] && !h_m[idx] && (((h_r[idx] >> s) & 1) == 1)) exp_ctrl[s] = '1;
    end
    idx = (cyc - NS) & 63;
    exp_done = net_out_val && h_v[idx] && h_l[idx];
    exp_busy = (m_rows != 0) || m_wait;
    for (int s = 1; s <= NS; s++) if (h_v[(cyc - s) & 63]) exp_busy = 1'b1;
    exp_state = m_wait ? 2'd2 : ((m_rows != 0) ? 2'd1 : 2'd0);

    chk("s_ready", 64'(s_ready), 64'(exp_ready));
    chk("net_in_val", 64'(net_in_val), 64'(exp_acc));
    chk("stage_ctrls", 64'(stage_ctrls), 64'(exp_ctrl));
    chk("frame_done", 64'(frame_done), 64'(exp_done));
    chk("busy", 64'(busy), 64'(exp_busy));
    chk("credit_err", 64'(credit_err), 64'(m_err));
    chk("credits", 64'(dbg_credits), 64'(m_credits));
    chk("state", 64'(dbg_state), 64'(exp_state));

    snap_ctrl[cyc & 63]  = stage_ctrls;
    snap_done[cyc & 63]  = frame_done;
    snap_ready[cyc & 63] = s_ready;

    // Advance the model to what the coming clock edge produces.
    if (!rst) begin
      m_rows = 0; m_wait = 1'b0; m_credits = C; m_err = 1'b0;
      for (int i = 0; i < 64; i++) h_v[i] = 1'b0;
    end else begin
      idx = cyc & 63;
      h_v[idx] = exp_acc;
      h_r[idx] = cur_row;
      h_m[idx] = cur_mode;
      h_l[idx] = (cur_row == NI - 1);
      if (exp_acc) begin
        if (m_rows == 0) m_mode = cfg_mode;
        m_rows++;
        if (m_rows == NI) begin
          m_rows = 0;
          m_wait = 1'b1;
        end
      end
      if (exp_done) m_wait = 1'b0;
      if (exp_acc && !credit_return) m_credits--;
      else if (!exp_acc && credit_return) begin
        if (m_credits == C) m_err = 1'b1;
        else                m_credits++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input logic mode, input logic ret, output int acc_cyc);
    bit taken = 0;
    acc_cyc = -1;
    s_valid = 1'b1;
    cfg_mode = mode;
    credit_return = ret;
    for (int k = 0; k < 50 && !taken; k++) begin
      @(negedge clk);
      if (s_ready) begin
        taken = 1;
        acc_cyc = cyc;
      end else begin
        tick();
      end
    end
    if (!taken) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_row timeout: got no s_ready, expected s_ready within 50 cycles");
    end
    tick();
    s_valid = 1'b0;
    credit_return = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int t[NI];
  int tt, n_acc;

  initial begin
    // Reset held with s_valid asserted.
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready", 64'(s_ready), 64'd0);
      chk("rst_in_val", 64'(net_in_val), 64'd0);
      chk("rst_ctrls", 64'(stage_ctrls), 64'd0);
      chk("rst_credits", 64'(dbg_credits), 64'd4);
    end
    tick();
    rst = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", 64'(s_ready), 64'd1);
    tick();

    // Transpose frame, back to back, credit returned from the second row.
    for (int k = 0; k < NI; k++) send_row(1'b0, k >= 1, t[k]);
    repeat (8) @(negedge clk);
    chk("tr_back_to_back", 64'(t[15] - t[0]), 64'd15);
    chk("tr_r5_s0", 64'(snap_ctrl[t[5] & 63][0]), 64'hFF);
    chk("tr_r5_s1", 64'(snap_ctrl[(t[5] + 1) & 63][1]), 64'h00);
    chk("tr_r5_s2", 64'(snap_ctrl[(t[5] + 2) & 63][2]), 64'hFF);
    chk("tr_r5_s3", 64'(snap_ctrl[(t[5] + 3) & 63][3]), 64'h00);
    chk("tr_done_early", 64'(snap_done[(t[15] + 3) & 63]), 64'd0);
    chk("tr_done", 64'(snap_done[(t[15] + 4) & 63]), 64'd1);
    for (int d = 1; d <= 4; d++) chk("tr_flush_ready", 64'(snap_ready[(t[15] + d) & 63]), 64'd0);
    chk("tr_ready_after", 64'(snap_ready[(t[15] + 5) & 63]), 64'd1);
    tick();

    // Pass-through frame, mode dropped to 0 halfway through.
    for (int k = 0; k < NI; k++) send_row(k < 8, k >= 1, t[k]);
    repeat (8) @(negedge clk);
    for (int c = t[0]; c <= t[15] + 3; c++) chk("pt_ctrls", 64'(snap_ctrl[c & 63]), 64'd0);

    // Refill credits (2 left), then exhaust them.
    tick();
    credit_return = 1'b1;
    tick();
    tick();
    credit_return = 1'b0;
    @(negedge clk);
    chk("refill_credits", 64'(dbg_credits), 64'd4);
    tick();
    s_valid = 1'b1;
    cfg_mode = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (s_ready) n_acc++;
      tick();
    end
    chk("exh_accepts", 64'(n_acc), 64'd4);
    @(negedge clk);
    chk("exh_ready", 64'(s_ready), 64'd0);
    tick();
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (s_ready) n_acc++;
      tick();
    end
    chk("one_credit_one_accept", 64'(n_acc), 64'd1);
    s_valid = 1'b0;
    credit_return = 1'b1;
    tick();
    s_valid = 1'b1;
    @(negedge clk);
    chk("same_cycle_ready", 64'(s_ready), 64'd1);
    tick();
    s_valid = 1'b0;
    credit_return = 1'b0;
    @(negedge clk);
    chk("same_cycle_credits", 64'(dbg_credits), 64'd1);
    tick();
    send_row(1'b0, 1'b0, tt);  // seventh row of this frame

    // Mid-frame reset.
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    repeat (12) @(negedge clk);
    for (int c = tt; c <= tt + 10; c++) chk("abort_no_done", 64'(snap_done[c & 63]), 64'd0);
    tick();
    send_row(1'b0, 1'b0, tt);
    repeat (6) @(negedge clk);
    for (int s = 0; s < NS; s++) chk("abort_row0_ctrls", 64'(snap_ctrl[(tt + s) & 63][s]), 64'd0);

    // Credit overflow (3 credits now).
    tick();
    credit_return = 1'b1;
    @(negedge clk);
    chk("ovf_pre_credits", 64'(dbg_credits), 64'd3);
    tick();
    @(negedge clk);
    chk("ovf_full_credits", 64'(dbg_credits), 64'd4);
    chk("ovf_err_clear", 64'(credit_err), 64'd0);
    tick();
    credit_return = 1'b0;
    @(negedge clk);
    chk("ovf_err_set", 64'(credit_err), 64'd1);
    chk("ovf_credits_held", 64'(dbg_credits), 64'd4);
    repeat (3) tick();
    @(negedge clk);
    chk("ovf_err_sticky", 64'(credit_err), 64'd1);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("ovf_err_reset", 64'(credit_err), 64'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: got no end of test, expected end before 200000 time units");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
